// File: rtl/code_conv_pipe_if.sv
// Handshake bundle for code_conv_pipe: input word/mode channel and converted output channel.
// out_parity exists only when CODE_CONV_PARITY_EN is defined.
interface code_conv_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef CODE_CONV_PARITY_EN
    logic             out_parity;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_parity
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_parity
    );
`else
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/code_conv_pipe.sv
// Purpose: 2-stage WIDTH-bit code converter (BIN2GRAY/GRAY2BIN/INC/REV); CODE_CONV_PARITY_EN adds out_parity.
// Latency: word accepted in cycle c is on out_data with out_valid in cycle c+2.
// Backpressure: valid/ready, 2-word capacity; in_ready is combinational from out_ready when both stages are full.
module code_conv_pipe #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    code_conv_pipe_if.slave   io
);

    localparam logic [1:0] MODE_B2G = 2'd0;
    localparam logic [1:0] MODE_G2B = 2'd1;
    localparam logic [1:0] MODE_INC = 2'd2;

    function automatic logic [WIDTH-1:0] convert(input logic [1:0] m, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        case (m)
            MODE_B2G: r = d ^ (d >> 1);
            MODE_G2B: begin
                // Prefix XOR running down from the MSB.
                r[WIDTH-1] = d[WIDTH-1];
                for (int i = WIDTH - 2; i >= 0; i--) begin
                    r[i] = r[i+1] ^ d[i];
                end
            end
            MODE_INC: r = d + WIDTH'(1);
            default: begin
                for (int i = 0; i < WIDTH; i++) begin
                    r[i] = d[WIDTH-1-i];
                end
            end
        endcase
        return r;
    endfunction

    logic             valid1_q, valid1_d;
    logic [1:0]       mode1_q,  mode1_d;
    logic [WIDTH-1:0] data1_q,  data1_d;
    logic             valid2_q, valid2_d;
    logic [WIDTH-1:0] data2_q,  data2_d;
    logic [WIDTH-1:0] conv_w;
    logic             adv1, adv2;
`ifdef CODE_CONV_PARITY_EN
    logic             parity2_q, parity2_d;
`endif

    assign conv_w = convert(mode1_q, data1_q);

    always_comb begin
        adv2     = !valid2_q || io.out_ready;
        adv1     = !valid1_q || adv2;
        valid1_d = valid1_q;
        mode1_d  = mode1_q;
        data1_d  = data1_q;
        valid2_d = valid2_q;
        data2_d  = data2_q;
`ifdef CODE_CONV_PARITY_EN
        parity2_d = parity2_q;
`endif
        if (adv2) begin
            valid2_d = valid1_q;
            if (valid1_q) begin
                data2_d = conv_w;
`ifdef CODE_CONV_PARITY_EN
                parity2_d = ^conv_w;
`endif
            end
        end
        if (adv1) begin
            valid1_d = io.in_valid;
            if (io.in_valid) begin
                mode1_d = io.in_mode;
                data1_d = io.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            mode1_q  <= 2'd0;
            data1_q  <= '0;
            valid2_q <= 1'b0;
            data2_q  <= '0;
`ifdef CODE_CONV_PARITY_EN
            parity2_q <= 1'b0;
`endif
        end else begin
            valid1_q <= valid1_d;
            mode1_q  <= mode1_d;
            data1_q  <= data1_d;
            valid2_q <= valid2_d;
            data2_q  <= data2_d;
`ifdef CODE_CONV_PARITY_EN
            parity2_q <= parity2_d;
`endif
        end
    end

    assign io.in_ready  = adv1;
    assign io.out_valid = valid2_q;
    assign io.out_data  = data2_q;
`ifdef CODE_CONV_PARITY_EN
    assign io.out_parity = parity2_q;
`endif

endmodule

// File: tb/tb_code_conv_pipe.sv
// Bench for code_conv_pipe: directed literal cases plus randomized traffic against a queue-based reference model.
// Define CODE_CONV_PARITY_EN to also check out_parity.
module tb_code_conv_pipe;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_conv_pipe_if #(.WIDTH(W)) io ();

    code_conv_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion from the mode rules using integer arithmetic.
    function automatic logic [W-1:0] ref_conv(input logic [1:0] m, input logic [W-1:0] d);
        int v, r;
        v = int'(d);
        r = 0;
        case (m)
            2'd0: r = v ^ (v / 2);
            2'd1: for (int s = v; s != 0; s = s / 2) r = r ^ s;
            2'd2: r = (v + 1) % (1 << W);
            default: for (int i = 0; i < W; i++) if (((v >> i) & 1) == 1) r = r + (1 << (W - 1 - i));
        endcase
        return W'(r);
    endfunction

    // Model: in-flight words with the cycle they were accepted. A word accepted
    // in cycle c is visible in cycle c+2 once it reaches the head of the queue.
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic [W-1:0] cap_q[$];
    int           cap_cyc[$];
    logic [W-1:0] last_q = '0;
    int           cyc = 0;
    bit           started = 1'b0;
    bit           vis, rdy_exp;
    logic [W-1:0] cur_exp;

    always @(negedge clk) begin
        vis     = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
        rdy_exp = !(exp_q.size() == 2 && !io.out_ready);
        cur_exp = vis ? exp_q[0] : last_q;
        if (started) begin
            chk("sb_out_valid", 32'(io.out_valid), 32'(vis));
            chk("sb_in_ready", 32'(io.in_ready), 32'(rdy_exp));
            chk(vis ? "sb_out_data" : "sb_out_data_hold", 32'(io.out_data), 32'(cur_exp));
`ifdef CODE_CONV_PARITY_EN
            chk("sb_out_parity", 32'(io.out_parity), 32'(^cur_exp));
`endif
        end
        if (io.out_valid === 1'b1 && io.out_ready === 1'b1 && started && !rst) begin
            cap_q.push_back(io.out_data);
            cap_cyc.push_back(cyc);
        end
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            last_q  = '0;
            started = 1'b1;
        end else if (started) begin
            if (vis && io.out_ready) begin
                last_q = exp_q.pop_front();
                void'(acc_q.pop_front());
            end
            if (io.in_valid && rdy_exp) begin
                exp_q.push_back(ref_conv(io.in_mode, io.in_data));
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic push_word(input logic [1:0] m, input logic [W-1:0] d);
        int n;
        @(posedge clk); #1;
        io.in_valid = 1'b1;
        io.in_mode  = m;
        io.in_data  = d;
        @(negedge clk);
        n = 0;
        while (!io.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            nchk++;
            nerr++;
            $display("FAIL push_timeout: in_ready=0 after 50 cycles, expected 1");
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic sweep(input string name, input logic [1:0] m, input logic [W-1:0] d,
                         input logic [W-1:0] exp, input logic expp);
        push_word(m, d);
        idle_in();
        @(negedge clk);
        chk({name, "_early"}, 32'(io.out_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(io.out_valid), 32'd1);
        chk({name, "_data"}, 32'(io.out_data), 32'(exp));
`ifdef CODE_CONV_PARITY_EN
        chk({name, "_parity"}, 32'(io.out_parity), 32'(expp));
`else
        if (expp === 1'bx) $display("unexpected parity arg");
`endif
    endtask

    logic [W-1:0] out0[16];
    logic [W-1:0] out1[16];
    logic         took, hold;

    initial begin
        io.in_valid  = 1'b0;
        io.in_mode   = 2'd0;
        io.in_data   = '0;
        io.out_ready = 1'b1;
        rst          = 1'b1;

        // Reset, then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_out_data", 32'(io.out_data), 32'd0);
        chk("rst_in_ready", 32'(io.in_ready), 32'd1);
`ifdef CODE_CONV_PARITY_EN
        chk("rst_out_parity", 32'(io.out_parity), 32'd0);
`endif

        // Mode sweep with exact two-cycle latency
        sweep("b2g", 2'd0, 4'b0101, 4'b0111, 1'b1);
        sweep("g2b", 2'd1, 4'b1000, 4'b1111, 1'b0);
        sweep("inc", 2'd2, 4'b1111, 4'b0000, 1'b0);
        sweep("rev", 2'd3, 4'b0001, 4'b1000, 1'b1);
        sweep("par_inc", 2'd2, 4'b0110, 4'b0111, 1'b1);
        sweep("par_rev", 2'd3, 4'b0011, 4'b1100, 1'b0);

        // Exhaustive streaming: 16 x BIN2GRAY then 16 x GRAY2BIN, back-to-back
        drain();
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++) push_word(2'(m), W'(x));
        idle_in();
        for (int n = 0; n < 40 && cap_q.size() < 32; n++) @(negedge clk);
        chk("stream_count", 32'(cap_q.size()), 32'd32);
        if (cap_q.size() == 32) begin
            chk("stream_no_gaps", 32'(cap_cyc[31] - cap_cyc[0]), 32'd31);
            for (int x = 0; x < 16; x++) begin
                out0[x] = cap_q[x];
                out1[x] = cap_q[16 + x];
            end
            for (int x = 0; x < 16; x++) chk("roundtrip", 32'(out1[out0[x]]), 32'(x));
        end

        // Backpressure: 3 words offered with out_ready low, only 2 fit
        drain();
        io.out_ready = 1'b0;
        push_word(2'd2, 4'b0011);
        push_word(2'd3, 4'b0110);
        @(posedge clk); #1;
        io.in_mode = 2'd0;
        io.in_data = 4'b1100;
        @(negedge clk);
        chk("bp_in_ready", 32'(io.in_ready), 32'd0);
        chk("bp_out_valid", 32'(io.out_valid), 32'd1);
        chk("bp_out_data", 32'(io.out_data), 32'(4'b0100));
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_data", 32'(io.out_data), 32'(4'b0100));
            chk("bp_stall_ready", 32'(io.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(io.in_ready), 32'd1);
        idle_in();
        repeat (6) @(negedge clk);
        chk("bp_count", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            chk("bp_word0", 32'(cap_q[0]), 32'(4'b0100));
            chk("bp_word1", 32'(cap_q[1]), 32'(4'b0110));
            chk("bp_word2", 32'(cap_q[2]), 32'(4'b1010));
        end

        // Reset with both stages full
        drain();
        io.out_ready = 1'b0;
        push_word(2'd0, 4'b1010);
        push_word(2'd1, 4'b0101);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(io.out_valid), 32'd0);
        chk("mrst_out_data", 32'(io.out_data), 32'd0);
        chk("mrst_in_ready", 32'(io.in_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("mrst_no_ghosts", 32'(cap_q.size()), 32'd0);

        // Randomized traffic; the source holds an unaccepted word stable
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            took = io.in_valid && io.in_ready;
            @(posedge clk); #1;
            hold = io.in_valid && !took && !rst;
            rst  = ($urandom_range(0, 249) == 0);
            if (!hold) begin
                io.in_valid = ($urandom_range(0, 3) != 0);
                io.in_mode  = 2'($urandom_range(0, 3));
                io.in_data  = W'($urandom);
            end
            io.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drain();
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", nchk, nerr);
        $fatal(1);
    end

endmodule
